// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC power sequencer: state codes, host command
// characters, serial writer op codes and the register frames those ops send.
package adc_seq_pkg;

  localparam logic [3:0] ST_OFF       = 4'd0;
  localparam logic [3:0] ST_ADC_WARM  = 4'd1;
  localparam logic [3:0] ST_ANA_WARM  = 4'd2;
  localparam logic [3:0] ST_INIT_WR   = 4'd3;
  localparam logic [3:0] ST_INIT_WAIT = 4'd4;
  localparam logic [3:0] ST_CAL_REQ   = 4'd5;
  localparam logic [3:0] ST_CAL       = 4'd6;
  localparam logic [3:0] ST_DES_EN    = 4'd7;
  localparam logic [3:0] ST_SAMPLING  = 4'd8;
  localparam logic [3:0] ST_DIS_IDLE  = 4'd9;
  localparam logic [3:0] ST_IDLE      = 4'd10;
  localparam logic [3:0] ST_WAKE      = 4'd11;
  localparam logic [3:0] ST_DIS_CAL   = 4'd12;
  localparam logic [3:0] ST_SHUTDOWN  = 4'd13;
  localparam logic [3:0] ST_FAULT     = 4'd14;

  typedef enum logic [3:0] {
    S_OFF       = ST_OFF,
    S_ADC_WARM  = ST_ADC_WARM,
    S_ANA_WARM  = ST_ANA_WARM,
    S_INIT_WR   = ST_INIT_WR,
    S_INIT_WAIT = ST_INIT_WAIT,
    S_CAL_REQ   = ST_CAL_REQ,
    S_CAL       = ST_CAL,
    S_DES_EN    = ST_DES_EN,
    S_SAMPLING  = ST_SAMPLING,
    S_DIS_IDLE  = ST_DIS_IDLE,
    S_IDLE      = ST_IDLE,
    S_WAKE      = ST_WAKE,
    S_DIS_CAL   = ST_DIS_CAL,
    S_SHUTDOWN  = ST_SHUTDOWN,
    S_FAULT     = ST_FAULT
  } state_t;

  // Host command characters (ASCII)
  localparam logic [7:0] CMD_ON    = 8'h4F; // "O"
  localparam logic [7:0] CMD_OFF   = 8'h6F; // "o"
  localparam logic [7:0] CMD_SLEEP = 8'h53; // "S"
  localparam logic [7:0] CMD_WAKE  = 8'h57; // "W"
  localparam logic [7:0] CMD_RECAL = 8'h43; // "C"

  typedef enum logic [1:0] {
    OP_INIT    = 2'd0,
    OP_DES_EN  = 2'd1,
    OP_DES_DIS = 2'd2
  } wr_op_t;

  // Serial frame: 8-bit register address followed by 16-bit data, MSB first
  localparam int WR_FRAME_W = 24;

  function automatic logic [WR_FRAME_W-1:0] wr_frame(input wr_op_t op);
    logic [WR_FRAME_W-1:0] f;
    case (op)
      OP_INIT:    f = {8'h00, 16'h2000}; // configuration register, normal operation
      OP_DES_EN:  f = {8'h02, 16'h0080}; // dual-edge sampling on
      OP_DES_DIS: f = {8'h02, 16'h0000}; // dual-edge sampling off
      default:    f = {8'h00, 16'h2000};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/adc_reg_writer.sv
// Serial register writer for the ADC control port. A one-cycle start loads
// the frame for the requested op and shifts it out MSB first, two clocks per
// bit (data set with SCLK low, sampled on SCLK rising). Select is active-low.
// Abort returns the writer to idle at once without a done pulse.
module adc_reg_writer
  import adc_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [1:0] i_op,
  input  logic       i_abort,
  output logic       o_sclk,
  output logic       o_sdata,
  output logic       o_select,
  output logic       o_done
);

  localparam logic [5:0] LAST_HALF = 6'(2 * WR_FRAME_W - 1);

  logic                  r_busy;
  logic                  r_sclk;
  logic                  r_sel_n;
  logic                  r_done;
  logic [5:0]            r_cnt;
  logic [WR_FRAME_W-1:0] r_shift;

  // Control: frame sequencing, clock generation, select and done pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sel_n <= 1'b1;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_busy  <= 1'b0;
        r_sclk  <= 1'b0;
        r_sel_n <= 1'b1;
        r_cnt   <= '0;
      end else if (i_start) begin
        r_busy  <= 1'b1;
        r_sclk  <= 1'b0;
        r_sel_n <= 1'b0;
        r_cnt   <= '0;
      end else if (r_busy) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST_HALF) begin
          r_busy  <= 1'b0;
          r_sclk  <= 1'b0;
          r_sel_n <= 1'b1;
          r_done  <= 1'b1;
        end else begin
          r_sclk <= ~r_sclk;
        end
      end
    end
  end

  // Data: load the frame on start, advance one bit after each SCLK high phase
  always_ff @(posedge i_clk) begin
    if (i_start && !i_abort) begin
      r_shift <= wr_frame(wr_op_t'(i_op));
    end else if (r_busy && r_sclk) begin
      r_shift <= {r_shift[WR_FRAME_W-2:0], 1'b0};
    end
  end

  assign o_sclk   = r_sclk;
  assign o_sdata  = r_busy & r_shift[WR_FRAME_W-1];
  assign o_select = r_sel_n;
  assign o_done   = r_done;

endmodule

// File: rtl/adc_power_sequencer.sv
// Power / init / calibration sequencer for one ADC. Drives the rail enables,
// PD and CAL pins and dual-edge-sampling register writes from host commands.
// Optional calibration watchdog: define ADC_CAL_TIMEOUT_EN to enable the
// CAL_TIMEOUT counter and the FAULT state; otherwise Fault is tied low.
module adc_power_sequencer
  import adc_seq_pkg::*;
#(
  parameter int TIMER_W     = 24,
  parameter int ADC_PWR_DLY = 256,
  parameter int ANA_PWR_DLY = 128,
  parameter int INIT_DLY    = 128,
  parameter int WAKE_DLY    = 128,
  parameter int SHDN_DLY    = 256,
  parameter int CAL_TIMEOUT = 1048576
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Cmd,
  input  logic       CmdValid,
  input  logic       OutToADCEnable,
  input  logic       Sleep,
  input  logic       WakeUp,
  input  logic       InCalRunning,
  output logic       ADCPower,
  output logic       AnalogPower,
  output logic       OutSclk,
  output logic       OutSdata,
  output logic       OutSelect,
  output logic       OutPD,
  output logic       OutCal,
  output logic       OutPDQ,
  output logic [3:0] State,
  output logic       Ready,
  output logic       Fault
);

  // A delay state exits on its last cycle, so it lasts exactly DLY cycles
  localparam logic [TIMER_W-1:0] ADC_LAST  = TIMER_W'(ADC_PWR_DLY - 1);
  localparam logic [TIMER_W-1:0] ANA_LAST  = TIMER_W'(ANA_PWR_DLY - 1);
  localparam logic [TIMER_W-1:0] INIT_LAST = TIMER_W'(INIT_DLY - 1);
  localparam logic [TIMER_W-1:0] WAKE_LAST = TIMER_W'(WAKE_DLY - 1);
  localparam logic [TIMER_W-1:0] SHDN_LAST = TIMER_W'(SHDN_DLY - 1);

  state_t             r_state;
  state_t             w_next;
  logic [TIMER_W-1:0] r_timer;
  logic               r_adc_pwr;
  logic               r_ana_pwr;
  logic               r_pd;
  logic               r_cal;
  logic               r_ready;
  logic               r_wr_start;
  logic [1:0]         r_wr_op;

  logic w_cmd_on;
  logic w_off_req;
  logic w_sleep_req;
  logic w_wake_req;
  logic w_recal_req;
  logic w_entering;
  logic w_next_is_wr;
  logic w_wr_abort;
  logic w_wr_done;
  logic w_wr_sclk;
  logic w_wr_sdata;
  logic w_wr_select;

  assign w_cmd_on    = CmdValid && (Cmd == CMD_ON);
  assign w_off_req   = CmdValid && (Cmd == CMD_OFF);
  assign w_sleep_req = (CmdValid && (Cmd == CMD_SLEEP)) || Sleep;
  assign w_wake_req  = (CmdValid && (Cmd == CMD_WAKE)) || WakeUp;
  assign w_recal_req = CmdValid && (Cmd == CMD_RECAL);

`ifdef ADC_CAL_TIMEOUT_EN
  localparam int                CAL_W    = $clog2(CAL_TIMEOUT + 1);
  localparam logic [CAL_W-1:0]  CAL_LAST = CAL_W'(CAL_TIMEOUT - 1);

  logic [CAL_W-1:0] r_cal_cnt;
  logic             r_fault;
  logic             w_in_cal;

  assign w_in_cal = (r_state == S_CAL_REQ) || (r_state == S_CAL);
`endif

  // Next-state: normal sequencing, then watchdog, then shutdown overrides all
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_OFF:       if (w_cmd_on) w_next = S_ADC_WARM;
      S_ADC_WARM:  if (r_timer == ADC_LAST) w_next = S_ANA_WARM;
      S_ANA_WARM:  if (r_timer == ANA_LAST) w_next = S_INIT_WR;
      S_INIT_WR:   if (w_wr_done) w_next = S_INIT_WAIT;
      S_INIT_WAIT: if (r_timer == INIT_LAST) w_next = S_CAL_REQ;
      S_CAL_REQ:   if (InCalRunning) w_next = S_CAL;
      S_CAL:       if (!InCalRunning) w_next = S_DES_EN;
      S_DES_EN:    if (w_wr_done) w_next = S_SAMPLING;
      S_SAMPLING: begin
        if (w_sleep_req)      w_next = S_DIS_IDLE;
        else if (w_recal_req) w_next = S_DIS_CAL;
      end
      S_DIS_IDLE:  if (w_wr_done) w_next = S_IDLE;
      S_IDLE:      if (w_wake_req) w_next = S_WAKE;
      S_WAKE:      if (r_timer == WAKE_LAST) w_next = S_DES_EN;
      S_DIS_CAL:   if (w_wr_done) w_next = S_CAL_REQ;
      S_SHUTDOWN:  if (r_timer == SHDN_LAST) w_next = S_OFF;
      S_FAULT:     w_next = S_FAULT;
      default:     w_next = S_OFF;
    endcase
`ifdef ADC_CAL_TIMEOUT_EN
    if (w_in_cal && (r_cal_cnt == CAL_LAST)) w_next = S_FAULT;
`endif
    if ((r_state != S_OFF) && (r_state != S_SHUTDOWN) &&
        (w_off_req || !OutToADCEnable)) begin
      w_next = S_SHUTDOWN;
    end
  end

  assign w_entering   = (w_next != r_state);
  assign w_next_is_wr = (w_next == S_INIT_WR) || (w_next == S_DES_EN) ||
                        (w_next == S_DIS_IDLE) || (w_next == S_DIS_CAL);
  assign w_wr_abort   = (w_next == S_SHUTDOWN);

  // State register, shared delay timer and registered status/pin outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_OFF;
      r_timer    <= '0;
      r_adc_pwr  <= 1'b0;
      r_ana_pwr  <= 1'b0;
      r_pd       <= 1'b0;
      r_cal      <= 1'b0;
      r_ready    <= 1'b0;
      r_wr_start <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_timer    <= w_entering ? '0 : r_timer + 1'b1;
      r_adc_pwr  <= (w_next != S_OFF);
      r_ana_pwr  <= OutToADCEnable && (w_next != S_OFF) &&
                    (w_next != S_ADC_WARM) && (w_next != S_SHUTDOWN);
      r_pd       <= (w_next == S_IDLE);
      r_cal      <= (w_next == S_CAL_REQ);
      r_ready    <= (w_next == S_SAMPLING);
      r_wr_start <= w_entering && w_next_is_wr;
    end
  end

  // Writer op follows the write state being entered
  always_ff @(posedge Clock) begin
    case (w_next)
      S_INIT_WR:             r_wr_op <= OP_INIT;
      S_DES_EN:              r_wr_op <= OP_DES_EN;
      S_DIS_IDLE, S_DIS_CAL: r_wr_op <= OP_DES_DIS;
      default:               r_wr_op <= r_wr_op;
    endcase
  end

`ifdef ADC_CAL_TIMEOUT_EN
  // Watchdog spans CAL_REQ and CAL; Fault is sticky until the sequencer is off
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_cal_cnt <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_cal_cnt <= w_in_cal ? r_cal_cnt + 1'b1 : '0;
      if (w_next == S_FAULT)    r_fault <= 1'b1;
      else if (w_next == S_OFF) r_fault <= 1'b0;
    end
  end

  assign Fault = r_fault;
`else
  // Without the watchdog the timeout value has no effect
  logic w_unused_cal_timeout;
  assign w_unused_cal_timeout = (CAL_TIMEOUT == 0);
  assign Fault = 1'b0;
`endif

  adc_reg_writer u_writer (
    .i_clk    (Clock),
    .i_rst    (Reset),
    .i_start  (r_wr_start),
    .i_op     (r_wr_op),
    .i_abort  (w_wr_abort),
    .o_sclk   (w_wr_sclk),
    .o_sdata  (w_wr_sdata),
    .o_select (w_wr_select),
    .o_done   (w_wr_done)
  );

  // ADC-facing pins float whenever pin drive is not permitted
  assign OutSclk   = OutToADCEnable ? w_wr_sclk   : 1'bz;
  assign OutSdata  = OutToADCEnable ? w_wr_sdata  : 1'bz;
  assign OutSelect = OutToADCEnable ? w_wr_select : 1'bz;
  assign OutPD     = OutToADCEnable ? r_pd        : 1'bz;
  assign OutCal    = OutToADCEnable ? r_cal       : 1'bz;
  assign OutPDQ    = 1'b0;

  assign ADCPower    = r_adc_pwr;
  assign AnalogPower = r_ana_pwr;
  assign Ready       = r_ready;
  assign State       = r_state;

endmodule

// File: tb/tb_adc_power_sequencer.sv
// Bench for adc_power_sequencer: scenario tasks with randomized timing and
// command choice, expected timing computed from the delay parameters.
module tb_adc_power_sequencer;
  import adc_seq_pkg::*;

  localparam int ADC_D  = 256;
  localparam int ANA_D  = 128;
  localparam int INIT_D = 128;
  localparam int WAKE_D = 128;
  localparam int SHDN_D = 256;
  localparam int CAL_TO = 1000;
  // 24-bit frame at two clocks per bit, plus the start cycle and the done cycle
  localparam int WR_LEN = 24 * 2 + 2;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Cmd = 8'h00;
  logic       CmdValid = 1'b0;
  logic       OutToADCEnable = 1'b1;
  logic       Sleep = 1'b0;
  logic       WakeUp = 1'b0;
  logic       InCalRunning = 1'b0;
  logic       ADCPower, AnalogPower, OutPDQ, Ready, Fault;
  logic [3:0] State;
  wire        OutSclk, OutSdata, OutSelect, OutPD, OutCal;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  adc_power_sequencer #(.CAL_TIMEOUT(CAL_TO)) u_dut (
    .Clock(Clock), .Reset(Reset), .Cmd(Cmd), .CmdValid(CmdValid),
    .OutToADCEnable(OutToADCEnable), .Sleep(Sleep), .WakeUp(WakeUp),
    .InCalRunning(InCalRunning), .ADCPower(ADCPower), .AnalogPower(AnalogPower),
    .OutSclk(OutSclk), .OutSdata(OutSdata), .OutSelect(OutSelect),
    .OutPD(OutPD), .OutCal(OutCal), .OutPDQ(OutPDQ), .State(State),
    .Ready(Ready), .Fault(Fault)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic advance(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] c);
    Cmd = c; CmdValid = 1'b1;
    tick();
    CmdValid = 1'b0; Cmd = 8'h00;
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, input string tag);
    int n = 0;
    while (State !== st && n < budget) begin tick(); n++; end
    checks++;
    if (State !== st) begin failures++; $display("FAIL %s: State=%0d required=%0d after %0d cycles", tag, State, st, n); end
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    Reset = 1'b1;
    advance(3);
    outs = {ADCPower, AnalogPower, Ready, Fault, OutPD, OutCal, OutPDQ};
    checks++; if (State !== ST_OFF) begin failures++; $display("FAIL rst_state: State=%0d required=%0d", State, ST_OFF); end
    checks++; if (outs !== 7'b0) begin failures++; $display("FAIL rst_outputs: outs=%b required=0000000", outs); end
    Reset = 1'b0;
    tick();
    // everything except "O" is ignored while off
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 3))
        0: send(CMD_OFF);
        1: send(CMD_SLEEP);
        2: send(CMD_WAKE);
        default: send(CMD_RECAL);
      endcase
    end
    Sleep = 1'b1; WakeUp = 1'b1; tick(); Sleep = 1'b0; WakeUp = 1'b0;
    checks++; if (State !== ST_OFF || ADCPower !== 1'b0) begin failures++; $display("FAIL off_ignores: State=%0d ADCPower=%b required State=%0d ADCPower=0", State, ADCPower, ST_OFF); end
  endtask

  task automatic test_power_up();
    int k, d, h, rises;
    logic prev;
    send(CMD_ON);
    checks++; if (State !== ST_ADC_WARM || ADCPower !== 1'b1 || AnalogPower !== 1'b0) begin failures++; $display("FAIL pu_adc_on: State=%0d ADCPower=%b AnalogPower=%b required %0d/1/0", State, ADCPower, AnalogPower, ST_ADC_WARM); end
    // a repeated "O" while powered must not disturb the warm-up timing
    k = $urandom_range(1, 200);
    advance(k - 1);
    send(CMD_ON);
    advance(ADC_D - 1 - k);
    checks++; if (State !== ST_ADC_WARM || AnalogPower !== 1'b0) begin failures++; $display("FAIL pu_ana_early: State=%0d AnalogPower=%b required %0d/0", State, AnalogPower, ST_ADC_WARM); end
    tick();
    checks++; if (State !== ST_ANA_WARM || AnalogPower !== 1'b1) begin failures++; $display("FAIL pu_ana_on: State=%0d AnalogPower=%b required %0d/1", State, AnalogPower, ST_ANA_WARM); end
    advance(ANA_D - 1);
    checks++; if (State !== ST_ANA_WARM) begin failures++; $display("FAIL pu_ana_len: State=%0d required=%0d", State, ST_ANA_WARM); end
    tick();
    checks++; if (State !== ST_INIT_WR) begin failures++; $display("FAIL pu_init_wr: State=%0d required=%0d", State, ST_INIT_WR); end
    rises = 0; prev = OutSclk;
    for (int i = 0; i < WR_LEN - 1; i++) begin
      tick();
      if (OutSclk === 1'b1 && prev !== 1'b1) rises++;
      prev = OutSclk;
    end
    checks++; if (State !== ST_INIT_WR || rises != 24) begin failures++; $display("FAIL pu_init_frame: State=%0d sclk_rises=%0d required %0d/24", State, rises, ST_INIT_WR); end
    tick();
    checks++; if (State !== ST_INIT_WAIT) begin failures++; $display("FAIL pu_init_wait: State=%0d required=%0d", State, ST_INIT_WAIT); end
    advance(INIT_D - 1);
    checks++; if (State !== ST_INIT_WAIT || OutCal !== 1'b0) begin failures++; $display("FAIL pu_init_len: State=%0d OutCal=%b required %0d/0", State, OutCal, ST_INIT_WAIT); end
    tick();
    checks++; if (State !== ST_CAL_REQ || OutCal !== 1'b1) begin failures++; $display("FAIL pu_cal_req: State=%0d OutCal=%b required %0d/1", State, OutCal, ST_CAL_REQ); end
    d = $urandom_range(0, 15);
    advance(d);
    InCalRunning = 1'b1;
    tick();
    checks++; if (State !== ST_CAL || OutCal !== 1'b0) begin failures++; $display("FAIL pu_cal: State=%0d OutCal=%b required %0d/0", State, OutCal, ST_CAL); end
    h = $urandom_range(1, 20);
    advance(h - 1);
    InCalRunning = 1'b0;
    tick();
    checks++; if (State !== ST_DES_EN || Ready !== 1'b0) begin failures++; $display("FAIL pu_des_en: State=%0d Ready=%b required %0d/0", State, Ready, ST_DES_EN); end
    advance(WR_LEN - 1);
    checks++; if (Ready !== 1'b0) begin failures++; $display("FAIL pu_ready_early: Ready=%b required=0", Ready); end
    tick();
    checks++; if (State !== ST_SAMPLING || Ready !== 1'b1) begin failures++; $display("FAIL pu_sampling: State=%0d Ready=%b required %0d/1", State, Ready, ST_SAMPLING); end
  endtask

  task automatic test_ignored_in_sampling();
    send(CMD_ON);
    send(CMD_WAKE);
    WakeUp = 1'b1; tick(); WakeUp = 1'b0;
    checks++; if (State !== ST_SAMPLING || Ready !== 1'b1) begin failures++; $display("FAIL samp_ignore: State=%0d Ready=%b required %0d/1", State, Ready, ST_SAMPLING); end
  endtask

  task automatic test_sleep_wake();
    if ($urandom_range(0, 1) == 1) begin Sleep = 1'b1; tick(); Sleep = 1'b0; end
    else send(CMD_SLEEP);
    checks++; if (State !== ST_DIS_IDLE || Ready !== 1'b0) begin failures++; $display("FAIL sw_dis_idle: State=%0d Ready=%b required %0d/0", State, Ready, ST_DIS_IDLE); end
    advance(WR_LEN - 1);
    checks++; if (State !== ST_DIS_IDLE || OutPD !== 1'b0) begin failures++; $display("FAIL sw_dis_len: State=%0d OutPD=%b required %0d/0", State, OutPD, ST_DIS_IDLE); end
    tick();
    checks++; if (State !== ST_IDLE || OutPD !== 1'b1) begin failures++; $display("FAIL sw_idle: State=%0d OutPD=%b required %0d/1", State, OutPD, ST_IDLE); end
    advance($urandom_range(0, 20));
    send(CMD_RECAL);
    checks++; if (State !== ST_IDLE) begin failures++; $display("FAIL sw_idle_ignore: State=%0d required=%0d", State, ST_IDLE); end
    if ($urandom_range(0, 1) == 1) begin WakeUp = 1'b1; tick(); WakeUp = 1'b0; end
    else send(CMD_WAKE);
    checks++; if (State !== ST_WAKE || OutPD !== 1'b0) begin failures++; $display("FAIL sw_wake: State=%0d OutPD=%b required %0d/0", State, OutPD, ST_WAKE); end
    advance(WAKE_D - 1);
    checks++; if (State !== ST_WAKE) begin failures++; $display("FAIL sw_wake_len: State=%0d required=%0d", State, ST_WAKE); end
    tick();
    checks++; if (State !== ST_DES_EN) begin failures++; $display("FAIL sw_des_en: State=%0d required=%0d", State, ST_DES_EN); end
    advance(WR_LEN);
    checks++; if (State !== ST_SAMPLING || Ready !== 1'b1) begin failures++; $display("FAIL sw_sampling: State=%0d Ready=%b required %0d/1", State, Ready, ST_SAMPLING); end
  endtask

  task automatic test_recal();
    send(CMD_RECAL);
    checks++; if (State !== ST_DIS_CAL) begin failures++; $display("FAIL rc_dis_cal: State=%0d required=%0d", State, ST_DIS_CAL); end
    advance(WR_LEN);
    checks++; if (State !== ST_CAL_REQ || OutCal !== 1'b1) begin failures++; $display("FAIL rc_cal_req: State=%0d OutCal=%b required %0d/1", State, OutCal, ST_CAL_REQ); end
    advance($urandom_range(0, 10));
    InCalRunning = 1'b1;
    advance($urandom_range(1, 15));
    InCalRunning = 1'b0;
    wait_state(ST_SAMPLING, WR_LEN + 5, "rc_back_to_sampling");
  endtask

  task automatic test_off_wins();
    Sleep = 1'b1;
    send(CMD_OFF);
    Sleep = 1'b0;
    checks++; if (State !== ST_SHUTDOWN || AnalogPower !== 1'b0 || ADCPower !== 1'b1 || Ready !== 1'b0) begin failures++; $display("FAIL ow_shutdown: State=%0d Ana=%b Adc=%b Ready=%b required %0d/0/1/0", State, AnalogPower, ADCPower, Ready, ST_SHUTDOWN); end
    advance(SHDN_D - 1);
    checks++; if (ADCPower !== 1'b1) begin failures++; $display("FAIL ow_adc_early: ADCPower=%b required=1", ADCPower); end
    tick();
    checks++; if (State !== ST_OFF || ADCPower !== 1'b0) begin failures++; $display("FAIL ow_off: State=%0d ADCPower=%b required %0d/0", State, ADCPower, ST_OFF); end
  endtask

  task automatic test_enable_loss();
    logic [4:0] pins;
    send(CMD_ON);
    wait_state(ST_INIT_WR, ADC_D + ANA_D + 5, "el_reach_init_wr");
    advance($urandom_range(3, 40));
    OutToADCEnable = 1'b0;
    #1;
    pins = {OutSclk, OutSdata, OutSelect, OutPD, OutCal};
    checks++; if (pins !== 5'bzzzzz && pins !== 5'b00000) begin failures++; $display("FAIL el_pins_released: pins=%b required=zzzzz", pins); end
    tick();
    checks++; if (State !== ST_SHUTDOWN || AnalogPower !== 1'b0) begin failures++; $display("FAIL el_shutdown: State=%0d AnalogPower=%b required %0d/0", State, AnalogPower, ST_SHUTDOWN); end
    OutToADCEnable = 1'b1;
    #1;
    checks++; if (OutSelect !== 1'b1 || OutSclk !== 1'b0) begin failures++; $display("FAIL el_writer_aborted: select=%b sclk=%b required 1/0", OutSelect, OutSclk); end
    advance(SHDN_D - 1);
    checks++; if (State !== ST_SHUTDOWN || ADCPower !== 1'b1) begin failures++; $display("FAIL el_shdn_len: State=%0d ADCPower=%b required %0d/1", State, ADCPower, ST_SHUTDOWN); end
    tick();
    checks++; if (State !== ST_OFF || ADCPower !== 1'b0) begin failures++; $display("FAIL el_off: State=%0d ADCPower=%b required %0d/0", State, ADCPower, ST_OFF); end
  endtask

  task automatic test_async_reset();
    logic [6:0] outs;
    send(CMD_ON);
    advance(ADC_D - 1 + $urandom_range(1, 100));
    checks++; if (State !== ST_ANA_WARM || AnalogPower !== 1'b1) begin failures++; $display("FAIL ar_in_ana_warm: State=%0d AnalogPower=%b required %0d/1", State, AnalogPower, ST_ANA_WARM); end
    #2;
    Reset = 1'b1;
    #1;
    outs = {ADCPower, AnalogPower, Ready, Fault, OutPD, OutCal, OutPDQ};
    checks++; if (State !== ST_OFF || outs !== 7'b0) begin failures++; $display("FAIL ar_immediate: State=%0d outs=%b required %0d/0000000", State, outs, ST_OFF); end
    tick();
    Reset = 1'b0;
    advance(3);
    checks++; if (State !== ST_OFF || ADCPower !== 1'b0) begin failures++; $display("FAIL ar_stays_off: State=%0d ADCPower=%b required %0d/0", State, ADCPower, ST_OFF); end
  endtask

  task automatic test_cal_watchdog();
    send(CMD_ON);
    wait_state(ST_CAL_REQ, ADC_D + ANA_D + WR_LEN + INIT_D + 5, "wd_reach_cal_req");
    InCalRunning = 1'b1;
`ifdef ADC_CAL_TIMEOUT_EN
    advance(CAL_TO - 1);
    checks++; if (State !== ST_CAL || Fault !== 1'b0) begin failures++; $display("FAIL wd_before: State=%0d Fault=%b required %0d/0", State, Fault, ST_CAL); end
    tick();
    checks++; if (State !== ST_FAULT || Fault !== 1'b1 || OutCal !== 1'b0 || AnalogPower !== 1'b1) begin failures++; $display("FAIL wd_fault: State=%0d Fault=%b OutCal=%b Ana=%b required %0d/1/0/1", State, Fault, OutCal, AnalogPower, ST_FAULT); end
    InCalRunning = 1'b0;
    advance(5);
    checks++; if (State !== ST_FAULT) begin failures++; $display("FAIL wd_sticky: State=%0d required=%0d", State, ST_FAULT); end
    send(CMD_OFF);
    checks++; if (State !== ST_SHUTDOWN || Fault !== 1'b1) begin failures++; $display("FAIL wd_shutdown: State=%0d Fault=%b required %0d/1", State, Fault, ST_SHUTDOWN); end
    advance(SHDN_D);
    checks++; if (State !== ST_OFF || Fault !== 1'b0) begin failures++; $display("FAIL wd_cleared: State=%0d Fault=%b required %0d/0", State, Fault, ST_OFF); end
`else
    advance(CAL_TO + 100);
    checks++; if (State !== ST_CAL || Fault !== 1'b0) begin failures++; $display("FAIL wd_absent: State=%0d Fault=%b required %0d/0", State, Fault, ST_CAL); end
    InCalRunning = 1'b0;
    tick();
    checks++; if (State !== ST_DES_EN) begin failures++; $display("FAIL wd_cal_end: State=%0d required=%0d", State, ST_DES_EN); end
    send(CMD_OFF);
    wait_state(ST_OFF, SHDN_D + 5, "wd_off");
`endif
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_ignored_in_sampling();
    test_sleep_wake();
    test_recal();
    test_off_wins();
    test_enable_loss();
    test_async_reset();
    test_cal_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, State=%0d", State);
    $fatal(1, "time limit");
  end

endmodule
